// File: rtl/mux2_arb_pkg.sv
// Shared state encoding, requester indices and counter sizing for the mux2_arb arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic int cnt_width(input int max_hold);
    return $clog2(max_hold);
  endfunction

endpackage

// File: rtl/mux2_arb_timer.sv
// Grant-hold counter for mux2_arb; fires when a grant reaches MAX_HOLD cycles while the other side waits.
module mux2_arb_timer
  import mux2_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic other_pending,
  output logic fire
);

  localparam int            CW    = cnt_width(MAX_HOLD);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt;

  // Saturates at LIMIT so an uncontested grant can run on without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fire = enable && other_pending && (cnt == LIMIT);

endmodule

// File: rtl/mux2_arb.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// Define MUX2_ARB_TIMEOUT_EN to build the hold-limit timer and the preempt pulse.
module mux2_arb
  import mux2_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       preempt
);

  state_t state;
  state_t nxt;
  logic   prio;
  logic   released;
  logic   entry;
  logic   fire;
  logic   preempt_nxt;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 65535)) begin : g_bad_max_hold
    $error("mux2_arb: MAX_HOLD must lie within 2..65535");
  end

`ifdef MUX2_ARB_TIMEOUT_EN
  mux2_arb_timer #(
    .MAX_HOLD(MAX_HOLD)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (entry),
    .enable       (state != IDLE),
    .other_pending((state == G1) ? req[0] : req[1]),
    .fire         (fire)
  );
`else
  assign fire = 1'b0;
`endif

  // On release the other requester goes first, then a back-to-back regrant, then idle.
  always_comb begin
    nxt         = state;
    released    = 1'b0;
    preempt_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req == 2'b11) begin
          nxt = (prio == REQ1) ? G0 : G1;
        end else if (req[0]) begin
          nxt = G0;
        end else if (req[1]) begin
          nxt = G1;
        end
      end
      G0: begin
        if (last[0] || !req[0] || fire) begin
          released    = 1'b1;
          nxt         = req[1] ? G1 : (req[0] ? G0 : IDLE);
          preempt_nxt = fire && !last[0] && req[0];
        end
      end
      G1: begin
        if (last[1] || !req[1] || fire) begin
          released    = 1'b1;
          nxt         = req[0] ? G0 : (req[1] ? G1 : IDLE);
          preempt_nxt = fire && !last[1] && req[1];
        end
      end
      default: nxt = IDLE;
    endcase
    entry = (nxt != IDLE) && ((state == IDLE) || released);
  end

  // Outputs are decoded from the next state so gnt and sel always move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      sel     <= 1'b0;
      busy    <= 1'b0;
      preempt <= 1'b0;
      prio    <= REQ1;
    end else begin
      state   <= nxt;
      busy    <= (nxt != IDLE);
      preempt <= preempt_nxt;
      case (nxt)
        G0: begin
          gnt <= 2'b01;
          sel <= 1'b0;
        end
        G1: begin
          gnt <= 2'b10;
          sel <= 1'b1;
        end
        default: gnt <= 2'b00;
      endcase
      if (entry) begin
        prio <= (nxt == G1) ? REQ1 : REQ0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_arb.sv
// Self-checking bench for mux2_arb: directed scenarios plus randomized traffic against an owner/priority model.
module tb_mux2_arb;

  localparam int MAX_HOLD = 4;
`ifdef MUX2_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_BUILT = 1'b1;
`else
  localparam bit TIMEOUT_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] last = 2'b00;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  // Model: who owns the mux, who was served last, how long the current grant has lasted.
  int m_owner;
  int m_prev;
  int m_held;
  bit m_sel;
  bit m_preempt;

  mux2_arb #(
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .last   (last),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner   = -1;
    m_prev    = 1;
    m_held    = 0;
    m_sel     = 1'b0;
    m_preempt = 1'b0;
  endfunction

  function automatic void grant_to(int who);
    m_owner = who;
    m_prev  = who;
    m_held  = 0;
    m_sel   = (who == 1);
  endfunction

  function automatic void model_step(logic [1:0] r, logic [1:0] l);
    int o;
    int other;
    bit timed_out;
    m_preempt = 1'b0;
    if (m_owner < 0) begin
      if (r == 2'b11) grant_to(1 - m_prev);
      else if (r[0]) grant_to(0);
      else if (r[1]) grant_to(1);
    end else begin
      o         = m_owner;
      other     = 1 - o;
      timed_out = TIMEOUT_BUILT && (m_held >= MAX_HOLD - 1) && r[other];
      if (l[o] || !r[o] || timed_out) begin
        m_preempt = timed_out && !l[o] && r[o];
        if (r[other]) grant_to(other);
        else if (r[o]) grant_to(o);
        else m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endfunction

  function automatic logic [1:0] exp_gnt();
    if (m_owner == 0) return 2'b01;
    if (m_owner == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_busy();
    return (m_owner >= 0);
  endfunction

  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] l);
    @(negedge clk);
    req  = r;
    last = l;
    @(posedge clk);
    model_step(r, l);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 2'b00;
    last = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("[TB] FAIL reset_preempt: got %b expected 0", preempt); end
    apply_stimulus(2'b10, 2'b00);
    checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL pre_reset_gnt: got %b expected %b", gnt, exp_gnt()); end
    checks++; if (sel !== m_sel) begin errors++; $display("[TB] FAIL pre_reset_sel: got %b expected %b", sel, m_sel); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL async_reset_gnt: got %b expected 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy); end
    checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_sel: got %b expected 0", sel); end
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply_stimulus(2'b01, 2'b00);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL post_reset_gnt: got %b expected 01", gnt); end
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(2'b11, (i == 4) ? 2'b01 : 2'b00);
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL tie_gnt cycle %0d: got %b expected %b", i, gnt, exp_gnt()); end
      checks++; if (sel !== m_sel) begin errors++; $display("[TB] FAIL tie_sel cycle %0d: got %b expected %b", i, sel, m_sel); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("[TB] FAIL tie_busy cycle %0d: got %b expected %b", i, busy, exp_busy()); end
      checks++; if (preempt !== m_preempt) begin errors++; $display("[TB] FAIL tie_preempt cycle %0d: got %b expected %b", i, preempt, m_preempt); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(2'b10, ((i % 3) == 2) ? 2'b10 : 2'b00);
      checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL b2b_gnt cycle %0d: got %b expected 10", i, gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy cycle %0d: got %b expected 1", i, busy); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    apply_stimulus(2'b01, 2'b00);
    apply_stimulus(2'b01, 2'b00);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL abort_pre_gnt: got %b expected 01", gnt); end
    apply_stimulus(2'b00, 2'b00);
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL abort_gnt: got %b expected 00", gnt); end
    checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL abort_sel: got %b expected 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      apply_stimulus(2'b11, 2'b00);
      if (preempt === 1'b1) pulses++;
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL timeout_gnt cycle %0d: got %b expected %b", i, gnt, exp_gnt()); end
      checks++; if (preempt !== m_preempt) begin errors++; $display("[TB] FAIL timeout_preempt cycle %0d: got %b expected %b", i, preempt, m_preempt); end
    end
    checks++;
    if (pulses != (TIMEOUT_BUILT ? 3 : 0)) begin
      errors++;
      $display("[TB] FAIL timeout_pulse_count: got %0d expected %0d", pulses, TIMEOUT_BUILT ? 3 : 0);
    end
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic [1:0] l;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) r = r | req;
      l = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      apply_stimulus(r, l);
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL rand_gnt cycle %0d: got %b expected %b", i, gnt, exp_gnt()); end
      checks++; if (sel !== m_sel) begin errors++; $display("[TB] FAIL rand_sel cycle %0d: got %b expected %b", i, sel, m_sel); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("[TB] FAIL rand_busy cycle %0d: got %b expected %b", i, busy, exp_busy()); end
      checks++; if (preempt !== m_preempt) begin errors++; $display("[TB] FAIL rand_preempt cycle %0d: got %b expected %b", i, preempt, m_preempt); end
    end
  endtask

  initial begin
    model_reset();
    $display("[TB] mux2_arb bench start, timeout built=%0d", TIMEOUT_BUILT);
    test_reset();
    test_tie();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
